// File: rtl/frame_dump_arbiter_pkg.sv
// Shared types and defaults for the frame dump arbiter and its address generator.
package frame_dump_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FIN
    } dump_state_t;

    localparam logic [1:0] PLANE_R = 2'd0;
    localparam logic [1:0] PLANE_G = 2'd1;
    localparam logic [1:0] PLANE_B = 2'd2;

    localparam int DEF_BASE_ADDR   = 120000;
    localparam int DEF_PLANE_WORDS = 40000;
    localparam int DEF_NUM_PLANES  = 3;

endpackage

// File: rtl/dump_addr_gen.sv
// Running read address plus separate word/plane up-counters for the frame dump.
// Flags the final word of the final plane so the FSM can finish without a divider.
module dump_addr_gen
    import frame_dump_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 128,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
    parameter int                PLANE_WORDS = DEF_PLANE_WORDS,
    parameter int                NUM_PLANES  = DEF_NUM_PLANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_plane,
    output logic              o_frame_last
);

    localparam int WORD_W = (PLANE_WORDS > 1) ? $clog2(PLANE_WORDS) : 1;

    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_plane;
    logic              w_word_last;

    assign w_word_last  = (r_word == WORD_W'(PLANE_WORDS - 1));
    assign o_frame_last = w_word_last && (r_plane == 2'(NUM_PLANES - 1));
    assign o_addr       = r_addr;
    assign o_plane      = r_plane;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_word  <= '0;
            r_plane <= PLANE_R;
        end else if (i_load) begin
            r_addr  <= BASE_ADDR;
            r_word  <= '0;
            r_plane <= PLANE_R;
        end else if (i_advance) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_word_last) begin
                r_word  <= '0;
                r_plane <= r_plane + 2'd1;
            end else begin
                r_word <= r_word + WORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_dump_arbiter.sv
// Streams the R/G/B planes out of data RAM using only port cycles the core leaves idle.
// Optional XOR checksum of dumped words is built when FRAME_DUMP_CHECKSUM_EN is defined.
module frame_dump_arbiter
    import frame_dump_arbiter_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                ADDR_W      = 128,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
    parameter int                PLANE_WORDS = DEF_PLANE_WORDS,
    parameter int                NUM_PLANES  = DEF_NUM_PLANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpuReq,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWd,
    input  logic              cpuWe,
    input  logic              cpuVf,
    output logic              cpuGrant,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWd,
    output logic              memWe,
    output logic              memVf,
    input  logic [DATA_W-1:0] memRd,
    output logic [DATA_W-1:0] outData,
    output logic [1:0]        outPlane,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    dump_state_t       r_state;
    dump_state_t       w_next;
    logic              w_load;
    logic              w_hs;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_plane;
    logic              w_frame_last;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_plane;

    assign w_load = (r_state == IDLE) && start;
    assign w_hs   = (r_state == HOLD) && outReady;

    dump_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .PLANE_WORDS (PLANE_WORDS),
        .NUM_PLANES  (NUM_PLANES)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_advance    (w_hs),
        .o_addr       (w_addr),
        .o_plane      (w_plane),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and a latch can never be inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = REQ;
            REQ:     if (!cpuReq) w_next = WAIT;
            WAIT:    w_next = HOLD;
            HOLD:    if (outReady) w_next = w_frame_last ? FIN : REQ;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The core owns the port except in an uncontended REQ cycle.
    always_comb begin
        cpuGrant = cpuReq;
        memAddr  = cpuAddr;
        memWd    = cpuWd;
        memWe    = cpuWe & cpuReq;
        memVf    = cpuVf & cpuReq;
        outValid = 1'b0;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        case (r_state)
            REQ: if (!cpuReq) begin
                memAddr = w_addr;
                memWd   = '0;
                memWe   = 1'b0;
                memVf   = 1'b0;
            end
            HOLD:    outValid = 1'b1;
            FIN:     done     = 1'b1;
            default: ;
        endcase
    end

    // Read data returns during WAIT; the plane tag is still that word's plane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_plane <= PLANE_R;
        end else if (r_state == WAIT) begin
            r_out_data  <= memRd;
            r_out_plane <= w_plane;
        end
    end

    assign outData  = r_out_data;
    assign outPlane = r_out_plane;

`ifdef FRAME_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_checksum <= '0;
        else if (w_load) r_checksum <= '0;
        else if (w_hs)   r_checksum <= r_checksum ^ r_out_data;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule
